// File: rtl/i2s_rx_pkg.sv
// Shared audio constants and stereo-word packing for the I2S capture path.
// Holds the default sample width, left/right word-select polarity and the
// {right,left} packing helper that the DAC side uses for the same layout.
package i2s_rx_pkg;

  localparam int SAMPLE_BITS_DEF = 16;  // captured bits per channel
  localparam int FIFO_DEPTH_DEF  = 16;  // stereo words buffered
  localparam int CH_BITS         = 16;  // bits per channel in a packed word
  localparam logic LRCK_LEFT     = 1'b0;  // word-select level of the left slot

  // Stereo buffer layout: right channel in the upper half.
  function automatic logic [2*CH_BITS-1:0] pack_stereo(input logic [CH_BITS-1:0] right,
                                                       input logic [CH_BITS-1:0] left);
    return {right, left};
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// Show-ahead synchronous FIFO for captured stereo words.
// Latency: write visible at rd_data/level the cycle after wr_en; rd_data is the head combinationally.
// Backpressure: wr_en while full is accepted only alongside a pop; otherwise the caller sees full and drops.
// Ports: clkin/reset_n clock and async reset; wr_en/wr_data push; rd_en pop (ignored when empty);
//        rd_data head word (0 when empty); level words held; full/empty status.
module i2s_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clkin,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers are power-of-two wide, so they wrap naturally.
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; rd_data is masked while empty.
  always_ff @(posedge clkin) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises SCLK/LRCK/SDIN, deserialises MSB-first words, queues {right,left}.
// Latency: rd_valid 5 clkin after the sclk rising edge carrying the last right-channel bit.
// Backpressure: none toward the I2S source; a full FIFO without a pop drops the word and sets overrun.
// Ports: clkin/reset_n clock and async reset; enable capture enable; sclk_in/lrck_in/sdin async I2S pins;
//        rd_ack/rd_data/rd_valid/fifo_level consumer side; overrun/frame_err sticky flags; status_clr clears them.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                        clkin,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        sclk_in,
  input  logic                        lrck_in,
  input  logic                        sdin,
  input  logic                        rd_ack,
  output logic [31:0]                 rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  output logic                        frame_err,
  input  logic                        status_clr
);

  // Shift register is at least one packed channel wide so short samples zero-fill the LSBs.
  localparam int SRW = (SAMPLE_BITS > CH_BITS) ? SAMPLE_BITS : CH_BITS;
  localparam int CW  = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0]  SB_C      = CW'(SAMPLE_BITS);
  localparam logic [SRW-1:0] SHREG_TOP = {1'b1, {(SRW-1){1'b0}}};

  // Pin synchronisers; lrck/sdin get the same delay as the sclk edge detector.
  logic [1:0] sclk_sync_q, lrck_sync_q, sdin_sync_q;
  logic       sclk_hist_q;
  logic       edge_q, lrck_q, sdin_q;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      lrck_sync_q <= '0;
      sdin_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      edge_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdin_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_in};
      lrck_sync_q <= {lrck_sync_q[0], lrck_in};
      sdin_sync_q <= {sdin_sync_q[0], sdin};
      sclk_hist_q <= sclk_sync_q[1];
      edge_q      <= sclk_sync_q[1] & ~sclk_hist_q;
      lrck_q      <= lrck_sync_q[1];
      sdin_q      <= sdin_sync_q[1];
    end
  end

  // Deserialiser state.
  logic               lrck_prev_q, ch_prev_q, hunt_q, hunt_d, en_q;
  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic [SRW-1:0]     shreg_q, shreg_d;
  logic               left_vld_q;
  logic [CH_BITS-1:0] left_q;
  logic               push_vld_q;
  logic [31:0]        push_dat_q;
  logic               overrun_q, frame_err_q;

  logic               ch, new_slot, word_vld, word_ch, short_slot;
  logic [CH_BITS-1:0] word;

  always_comb begin
    // The channel owning this bit is the word-select seen one bit earlier.
    ch         = lrck_prev_q;
    new_slot   = edge_q && (ch != ch_prev_q);
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    hunt_d     = hunt_q;
    word_vld   = 1'b0;
    word_ch    = ch_prev_q;
    short_slot = 1'b0;
    word       = shreg_q[SRW-1 -: CH_BITS];
    if (new_slot) begin
      // A slot that ends before filling still yields its left-justified bits.
      if (!hunt_q && (bitcnt_q < SB_C)) begin
        word_vld   = 1'b1;
        short_slot = 1'b1;
      end
      bitcnt_d = CW'(1);
      shreg_d  = sdin_q ? SHREG_TOP : '0;
      if (ch == LRCK_LEFT) hunt_d = 1'b0;
    end else if (edge_q && (bitcnt_q < SB_C)) begin
      bitcnt_d = bitcnt_q + CW'(1);
      if (sdin_q) shreg_d = shreg_q | (SHREG_TOP >> bitcnt_q);
      if (!hunt_q && (bitcnt_d == SB_C)) begin
        word_vld = 1'b1;
        word_ch  = ch;
        word     = shreg_d[SRW-1 -: CH_BITS];
      end
    end
    // While disabled, and on the cycle enable returns, realign to the next left slot.
    if (!enable || !en_q) begin
      hunt_d   = 1'b1;
      word_vld = 1'b0;
    end
  end

  logic fifo_full, fifo_empty, fifo_wr, fifo_ovf;

  assign fifo_wr  = push_vld_q & enable;
  assign fifo_ovf = fifo_wr & fifo_full & ~(rd_ack & ~fifo_empty);

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      en_q        <= 1'b0;
      lrck_prev_q <= 1'b0;
      ch_prev_q   <= 1'b0;
      hunt_q      <= 1'b1;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      left_vld_q  <= 1'b0;
      left_q      <= '0;
      push_vld_q  <= 1'b0;
      push_dat_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      en_q     <= enable;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      hunt_q   <= hunt_d;
      if (edge_q) begin
        lrck_prev_q <= lrck_q;
        ch_prev_q   <= ch;
      end
      push_vld_q <= 1'b0;
      if (!enable) begin
        left_vld_q <= 1'b0;
      end else if (word_vld) begin
        if (word_ch == LRCK_LEFT) begin
          left_q     <= word;
          left_vld_q <= 1'b1;
        end else begin
          // A right word only counts if its left partner arrived in this frame.
          if (left_vld_q) begin
            push_vld_q <= 1'b1;
            push_dat_q <= pack_stereo(word, left_q);
          end
          left_vld_q <= 1'b0;
        end
      end
      // Clear first so a coinciding new event wins.
      overrun_q   <= (overrun_q & ~status_clr) | fifo_ovf;
      frame_err_q <= (frame_err_q & ~status_clr) | (word_vld & short_slot);
    end
  end

  i2s_rx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clkin   (clkin),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (push_dat_q),
    .rd_en   (rd_ack),
    .rd_data (rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid  = ~fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

  logic        clkin = 1'b0;
  logic        reset_n, enable, sclk_in, lrck_in, sdin, rd_ack, status_clr;
  logic [31:0] rd_data;
  logic        rd_valid, overrun, frame_err;
  logic [4:0]  fifo_level;

  i2s_rx #(.SAMPLE_BITS(16), .FIFO_DEPTH(16)) dut (
    .clkin(clkin), .reset_n(reset_n), .enable(enable), .sclk_in(sclk_in),
    .lrck_in(lrck_in), .sdin(sdin), .rd_ack(rd_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_level(fifo_level), .overrun(overrun),
    .frame_err(frame_err), .status_clr(status_clr)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_bad = 0;
  int   bit_idx = -1;
  int   last_rise_cyc = 0;
  int   rv_rise_cyc = -1;
  logic rv_prev = 1'b0;

  // First cycle in which rd_valid is seen high after being low.
  always @(negedge clkin) begin
    if (rd_valid === 1'b1 && rv_prev !== 1'b1) rv_rise_cyc = cyc;
    rv_prev = rd_valid;
  end

  initial begin
    repeat (95000) @(posedge clkin);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles required < 95000", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct { logic ch; logic d; } sbit_t;
  sbit_t stream[$];

  typedef struct {
    int          nl;
    int          nr;
    logic [31:0] lv;
    logic [31:0] rv;
    logic [31:0] exp_word;
    logic        exp_ferr;
  } vec_t;
  vec_t tbl[6];

  logic [31:0] expq[$];
  logic        exp_ovr;

  task automatic tick(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_slot(input logic ch, input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) stream.push_back('{ch, v[i]});
  endtask

  // Plays the queued bits with I2S word-select lookahead. A lead bit announces the
  // first channel. With ack_last, rd_ack is pulsed on the cycle the final word is pushed.
  task automatic play(input bit ack_last);
    lrck_in = stream[0].ch; sdin = 1'b0; sclk_in = 1'b0; tick(8);
    sclk_in = 1'b1; tick(8);
    for (int i = 0; i < stream.size(); i++) begin
      bit_idx = i;
      sclk_in = 1'b0;
      sdin    = stream[i].d;
      lrck_in = (i + 1 < stream.size()) ? stream[i+1].ch : stream[i].ch;
      tick(8);
      sclk_in = 1'b1;
      last_rise_cyc = cyc;
      if (ack_last && i == stream.size() - 1) begin
        tick(4); rd_ack = 1'b1; tick(1); rd_ack = 1'b0; tick(3);
      end else begin
        tick(8);
      end
    end
    stream.delete();
  endtask

  task automatic pop();
    rd_ack = 1'b1; tick(1); rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick(3); reset_n = 1'b1; enable = 1'b1; tick(4);
  endtask

  // Sample as seen by the consumer: top 16 received bits, zero-padded if the slot was short.
  function automatic logic [15:0] exp_chan(input int n, input logic [31:0] v);
    logic [31:0] m;
    m = v & ((32'd1 << n) - 32'd1);
    if (n >= 16) return 16'(m >> (n - 16));
    return 16'(m << (16 - n));
  endfunction

  function automatic void model_push(input logic [31:0] w);
    if (expq.size() < 16) expq.push_back(w);
    else exp_ovr = 1'b1;
  endfunction

  initial begin
    logic [31:0] lv, rv, w;
    int          nl, nr;
    logic        ferr;

    tbl[0] = '{16, 16, 32'h1234,   32'hABCD,   32'hABCD1234, 1'b0};
    tbl[1] = '{12, 16, 32'hFFF,    32'h0001,   32'h0001FFF0, 1'b1};
    tbl[2] = '{24, 16, 32'h8000AA, 32'h7FFF,   32'h7FFF8000, 1'b0};
    tbl[3] = '{16, 24, 32'h0000,   32'h123456, 32'h12340000, 1'b0};
    tbl[4] = '{16, 8,  32'hFFFF,   32'hA5,     32'hA500FFFF, 1'b1};
    tbl[5] = '{20, 20, 32'hABCDE,  32'h12345,  32'h1234ABCD, 1'b0};

    reset_n = 1'b1; enable = 1'b0; sclk_in = 1'b0; lrck_in = 1'b0; sdin = 1'b0;
    rd_ack = 1'b0; status_clr = 1'b0;
    #1 reset_n = 1'b0;
    tick(3);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset level", 32'(fifo_level), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    reset_n = 1'b1; enable = 1'b1; tick(4);

    // Basic frame and pin-to-rd_valid latency.
    add_slot(1'b1, 4, 32'h0);
    add_slot(1'b0, 16, 32'h1234);
    add_slot(1'b1, 16, 32'hABCD);
    rv_rise_cyc = -1;
    play(1'b0);
    tick(8);
    check("latency", 32'(rv_rise_cyc - last_rise_cyc), 32'd5);
    check("basic rd_data", rd_data, 32'hABCD1234);
    check("basic level", 32'(fifo_level), 32'd1);
    check("basic frame_err", 32'(frame_err), 32'd0);
    pop(); tick(1);
    check("basic pop empty", 32'(rd_valid), 32'd0);

    // Slot-length vectors.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      add_slot(1'b1, 4, 32'h0);
      add_slot(1'b0, tbl[v].nl, tbl[v].lv);
      add_slot(1'b1, tbl[v].nr, tbl[v].rv);
      add_slot(1'b0, 1, 32'h0);
      play(1'b0);
      tick(8);
      check($sformatf("vec%0d rd_data", v), rd_data, tbl[v].exp_word);
      check($sformatf("vec%0d level", v), 32'(fifo_level), 32'd1);
      check($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(tbl[v].exp_ferr));
    end

    // Randomised continuous streams with mixed slot lengths.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      expq.delete(); ferr = 1'b0;
      add_slot(1'b1, 4, 32'h0);
      for (int k = 0; k < 12; k++) begin
        nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 24)) : 16;
        nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 24)) : 16;
        lv = $urandom; rv = $urandom;
        add_slot(1'b0, nl, lv);
        add_slot(1'b1, nr, rv);
        expq.push_back({exp_chan(nr, rv), exp_chan(nl, lv)});
        if (nl < 16 || nr < 16) ferr = 1'b1;
      end
      add_slot(1'b0, 1, 32'h0);
      play(1'b0);
      tick(8);
      check("rand level", 32'(fifo_level), 32'(expq.size()));
      check("rand frame_err", 32'(frame_err), 32'(ferr));
      while (expq.size() > 0) begin
        w = expq.pop_front();
        check("rand rd_data", rd_data, w);
        pop();
      end
      tick(1);
      check("rand drained", 32'(rd_valid), 32'd0);
    end

    // Overrun, status clear, then push+pop on a full FIFO.
    do_reset();
    expq.delete(); exp_ovr = 1'b0;
    add_slot(1'b1, 4, 32'h0);
    for (int k = 0; k < 20; k++) begin
      lv = 32'($urandom_range(0, 65535)); rv = 32'($urandom_range(0, 65535));
      add_slot(1'b0, 16, lv);
      add_slot(1'b1, 16, rv);
      model_push({rv[15:0], lv[15:0]});
    end
    play(1'b0);
    tick(8);
    check("full level", 32'(fifo_level), 32'(expq.size()));
    check("full overrun", 32'(overrun), 32'(exp_ovr));
    check("full head", rd_data, expq[0]);
    status_clr = 1'b1; tick(1); status_clr = 1'b0; tick(1);
    check("overrun cleared", 32'(overrun), 32'd0);
    lv = 32'($urandom_range(0, 65535)); rv = 32'($urandom_range(0, 65535));
    add_slot(1'b0, 16, lv);
    add_slot(1'b1, 16, rv);
    play(1'b1);
    void'(expq.pop_front());
    expq.push_back({rv[15:0], lv[15:0]});
    tick(8);
    check("pushpop level", 32'(fifo_level), 32'd16);
    check("pushpop overrun", 32'(overrun), 32'd0);
    while (expq.size() > 0) begin
      w = expq.pop_front();
      check("drain rd_data", rd_data, w);
      pop();
    end
    tick(1);
    check("drain level", 32'(fifo_level), 32'd0);

    // Enable rising mid right slot: only the next full pair is captured.
    do_reset();
    enable = 1'b0;
    add_slot(1'b1, 4, 32'h0);
    add_slot(1'b0, 16, 32'h1111);
    add_slot(1'b1, 16, 32'h2222);
    add_slot(1'b0, 16, 32'h3333);
    add_slot(1'b1, 16, 32'h4444);
    bit_idx = -1;
    fork
      play(1'b0);
      begin
        wait (bit_idx >= 28);
        enable = 1'b1;
      end
    join
    tick(8);
    check("enable level", 32'(fifo_level), 32'd1);
    check("enable rd_data", rd_data, 32'h44443333);

    // Reset mid left slot with three words queued.
    do_reset();
    add_slot(1'b1, 4, 32'h0);
    add_slot(1'b0, 12, 32'h5A5);
    add_slot(1'b1, 16, 32'h0102);
    for (int k = 0; k < 2; k++) begin
      add_slot(1'b0, 16, 32'h0303);
      add_slot(1'b1, 16, 32'h0404);
    end
    play(1'b0);
    tick(8);
    check("pre-reset level", 32'(fifo_level), 32'd3);
    check("pre-reset frame_err", 32'(frame_err), 32'd1);
    add_slot(1'b0, 16, 32'h7777);
    add_slot(1'b1, 16, 32'h8888);
    add_slot(1'b0, 16, 32'h9999);
    add_slot(1'b1, 16, 32'hAAAA);
    bit_idx = -1;
    fork
      play(1'b0);
      begin
        wait (bit_idx >= 6);
        reset_n = 1'b0;
        tick(2);
        check("midreset rd_valid", 32'(rd_valid), 32'd0);
        check("midreset level", 32'(fifo_level), 32'd0);
        check("midreset overrun", 32'(overrun), 32'd0);
        check("midreset frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
      end
    join
    tick(8);
    check("resume level", 32'(fifo_level), 32'd1);
    check("resume rd_data", rd_data, 32'hAAAA9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
